pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Consumer side of the PLL wrapper's `locked`/`rst` interface.
- Runs on the PLL reference clock (74.25 MHz), so it keeps running while the PLL is unlocked.
- Synchronises the asynchronous `locked` output and qualifies it over a stable window before releasing the core reset. Re-asserts the core reset on lock loss.
- Pulses the PLL's `rst` input when lock is not achieved within a timeout, counts lock losses and PLL retries, and feeds the core reset tree.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before the core is released; legal range 2..65535.
- LOCK_TIMEOUT, 1048576: cycles allowed in WAIT_LOCK before a PLL reset is issued; legal range 2..2^24.
- PLL_RST_CYCLES, 16: width of the pll_rst pulse in cycles; legal range 1..255.
- CNT_W, 8: width of the saturating loss and retry counters.
- LOSS_FILTER, 4: consecutive low cycles required to declare a loss; used only with the optional feature; legal range 1..255.

Ports:
- refclk, input, 1: reference clock; the only clock in the block.
- rst, input, 1: asynchronous, active-high reset.
- locked, input, 1: PLL locked output; asynchronous to refclk.
- pll_rst, output, 1: reset request to the PLL.
- core_reset, output, 1: active-high reset to the clocked core logic.
- ready, output, 1: high while in RUN.
- lock_lost, output, 1: one-cycle pulse on a declared lock loss.
- loss_count, output, CNT_W: number of lock losses, saturating.
- retry_count, output, CNT_W: number of PLL resets issued, saturating.

Behaviour:
- All outputs are registered. While rst is high:
  - pll_rst=0, core_reset=1, ready=0, lock_lost=0, loss_count=0, retry_count=0.
  - State is WAIT_LOCK, counters are 0, synchroniser flops are 0.
- rst asserted at any point aborts the current operation immediately, including mid-pll_rst-pulse; pll_rst drops asynchronously.
- locked passes through a 2-flop synchroniser to form locked_s. locked_s is valid 2 edges after `locked` is first sampled.
- States:
  - WAIT_LOCK: the timer counts up each cycle.
    - locked_s=1 -> STABLE, cnt cleared.
    - timer reaches LOCK_TIMEOUT-1 while locked_s=0 -> PLL_RST.
  - STABLE:
    - locked_s=0 -> WAIT_LOCK, timer cleared; this is not counted as a loss.
    - otherwise cnt increments; when cnt==STABLE_CYCLES-1 -> RUN.
  - RUN: core_reset=0, ready=1. locked_s=0 -> loss declared.
  - PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then -> WAIT_LOCK with timer cleared. locked is ignored in this state.
- core_reset and ready are registered from the next state.
  - core_reset falls on clock edge N+STABLE_CYCLES+2, where edge N is the first edge that samples locked high.
  - core_reset rises on the edge that leaves RUN.
- Loss declaration, in a single cycle:
  - core_reset=1, ready=0, lock_lost=1 for one cycle.
  - loss_count increments (saturating at 2^CNT_W-1).
  - next state WAIT_LOCK, timer cleared.
- Entering PLL_RST increments retry_count (saturating).
- Counter widths: cnt uses clog2(STABLE_CYCLES); the timer uses clog2(LOCK_TIMEOUT). Neither counter wraps.
- locked toggling during STABLE repeatedly restarts qualification. core_reset never glitches low outside RUN.
- `locked` held high permanently gives a single release; no PLL reset is ever issued.

Optional Feature:
- Macro: PLL_LOCK_SUPERVISOR_LOSS_FILTER_EN.
- Defined:
  - In RUN, a loss is declared only after locked_s has been 0 for LOSS_FILTER consecutive cycles.
  - Any dip shorter than that is ignored entirely: no lock_lost pulse, no counter change, core_reset stays 0.
  - The filter counter clears whenever locked_s=1.
- Undefined: a single cycle of locked_s=0 in RUN declares a loss. The LOSS_FILTER parameter has no effect.

Test Plan:
- Reset and release, STABLE_CYCLES=8: hold rst for 5 cycles, then release with locked=1 constant -> core_reset=1 and ready=0 until edge 10 after locked is first sampled, then core_reset=0 and ready=1; pll_rst never asserted.
- Lock timeout, LOCK_TIMEOUT=32, PLL_RST_CYCLES=4: keep locked=0 -> pll_rst high for exactly 4 cycles starting 32 cycles after WAIT_LOCK entry; retry_count=1; after 3 timeouts retry_count=3.
- Loss in RUN, filter undefined: reach RUN, then drop locked for 1 cycle -> one lock_lost pulse, loss_count=1, core_reset=1; re-qualification takes a further STABLE_CYCLES before release.
- Filter defined, LOSS_FILTER=4: 3-cycle dip -> no change, core_reset stays 0; 5-cycle dip -> loss_count=1, lock_lost pulses once.
- Unstable lock: toggle locked every 5 cycles with STABLE_CYCLES=8 -> core_reset stays 1, loss_count=0, no lock_lost pulse; rst asserted mid-PLL_RST -> pll_rst=0 immediately and both counters=0.
- Saturation, CNT_W=2: force 5 losses -> loss_count=3 and no wrap to 0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor on the reference clock: synchronises and qualifies `locked`,
// drives the core reset, retries the PLL on timeout. Optional loss filter: PLL_LOCK_SUPERVISOR_LOSS_FILTER_EN.
module pll_lock_supervisor #(
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int PLL_RST_CYCLES = 16,
  parameter int CNT_W          = 8,
  parameter int LOSS_FILTER    = 4
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_rst,
  output logic             core_reset,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] retry_count
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(LOCK_TIMEOUT);
  localparam int PW = 8;
  localparam int FW = $clog2(LOSS_FILTER + 1);
`ifdef PLL_LOCK_SUPERVISOR_LOSS_FILTER_EN
  localparam int FILT_N = LOSS_FILTER;
`else
  localparam int FILT_N = 1;
`endif

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [PW-1:0] PRST_LAST   = PW'(PLL_RST_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST   = FW'(FILT_N - 1);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN, PLL_RST} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [SW-1:0] cnt, cnt_n;
  logic [PW-1:0] prst_cnt, prst_cnt_n;
  logic [FW-1:0] filt, filt_n;
  logic          sync_q1, locked_s;
  logic          loss, retry;

  // NOTE: reset clears the synchroniser too, so a stale `locked` cannot leak past rst.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= locked;
      locked_s <= sync_q1;
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    cnt_n      = cnt;
    prst_cnt_n = prst_cnt;
    filt_n     = filt;
    loss       = 1'b0;
    retry      = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (timer == TIMER_LAST) begin
          state_n    = PLL_RST;
          prst_cnt_n = '0;
          retry      = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          timer_n = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = RUN;
        end else begin
          cnt_n = cnt + SW'(1);
        end
      end
      RUN: begin
        // Without the filter FILT_LAST is 0, so the first low cycle is a loss.
        if (locked_s) begin
          filt_n = '0;
        end else if (filt == FILT_LAST) begin
          loss    = 1'b1;
          state_n = WAIT_LOCK;
          timer_n = '0;
          filt_n  = '0;
        end else begin
          filt_n = filt + FW'(1);
        end
      end
      PLL_RST: begin
        if (prst_cnt == PRST_LAST) begin
          state_n = WAIT_LOCK;
          timer_n = '0;
        end else begin
          prst_cnt_n = prst_cnt + PW'(1);
        end
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_LOCK;
      timer       <= '0;
      cnt         <= '0;
      prst_cnt    <= '0;
      filt        <= '0;
      pll_rst     <= 1'b0;
      core_reset  <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      loss_count  <= '0;
      retry_count <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      cnt        <= cnt_n;
      prst_cnt   <= prst_cnt_n;
      filt       <= filt_n;
      // Outputs follow the next state so they change on the same edge as the state.
      pll_rst    <= (state_n == PLL_RST);
      core_reset <= (state_n != RUN);
      ready      <= (state_n == RUN);
      lock_lost  <= loss;
      if (loss && (loss_count != '1))
        loss_count <= loss_count + CNT_W'(1);
      if (retry && (retry_count != '1))
        retry_count <= retry_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: release timing, loss, filter, unstable lock,
// timeout retries, reset mid-pulse and counter saturation.
module tb_pll_lock_supervisor;

  localparam int SC  = 8;
  localparam int LT  = 32;
  localparam int PRC = 4;
  localparam int CW  = 2;
  localparam int LF  = 4;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_FILTER_EN
  localparam int DIP = 5;
`else
  localparam int DIP = 1;
`endif

  logic          refclk = 1'b0;
  logic          rst    = 1'b1;
  logic          locked = 1'b0;
  logic          pll_rst, core_reset, ready, lock_lost;
  logic [CW-1:0] loss_count, retry_count;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_supervisor #(
    .STABLE_CYCLES (SC),
    .LOCK_TIMEOUT  (LT),
    .PLL_RST_CYCLES(PRC),
    .CNT_W         (CW),
    .LOSS_FILTER   (LF)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .loss_count (loss_count),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic apply_reset(input logic lk);
    rst    = 1'b1;
    locked = lk;
    step(5);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    locked = 1'b1;
    step(3);
    n_cmp++; if (pll_rst !== 1'b0) begin n_err++; $display("FAIL reset_pll_rst: got %b want 0", pll_rst); end
    n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
    n_cmp++; if (loss_count !== 2'd0) begin n_err++; $display("FAIL reset_loss_count: got %0d want 0", loss_count); end
    n_cmp++; if (retry_count !== 2'd0) begin n_err++; $display("FAIL reset_retry_count: got %0d want 0", retry_count); end
  endtask

  // Edge 1 after release first samples locked; core_reset falls on edge 1+SC+2.
  task automatic test_release;
    logic exp_cr;
    step(2);
    rst = 1'b0;
    for (int e = 1; e <= SC + 3; e++) begin
      step();
      exp_cr = (e >= SC + 3) ? 1'b0 : 1'b1;
      n_cmp++; if (core_reset !== exp_cr) begin n_err++; $display("FAIL release_core_reset e=%0d: got %b want %b", e, core_reset, exp_cr); end
      n_cmp++; if (ready !== ~exp_cr) begin n_err++; $display("FAIL release_ready e=%0d: got %b want %b", e, ready, ~exp_cr); end
      n_cmp++; if (pll_rst !== 1'b0) begin n_err++; $display("FAIL release_pll_rst e=%0d: got %b want 0", e, pll_rst); end
    end
  endtask

  task automatic test_loss;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL loss_pre_ready: got %b want 1", ready); end
    locked = 1'b0;
    step();
    locked = 1'b1;
    step(2);
    n_cmp++; if (lock_lost !== 1'b1) begin n_err++; $display("FAIL loss_pulse: got %b want 1", lock_lost); end
    n_cmp++; if (loss_count !== 2'd1) begin n_err++; $display("FAIL loss_count: got %0d want 1", loss_count); end
    n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL loss_core_reset: got %b want 1", core_reset); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL loss_ready: got %b want 0", ready); end
    step();
    n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL loss_pulse_end: got %b want 0", lock_lost); end
    step(SC - 1);
    n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL loss_requal_early: got %b want 1", core_reset); end
    step();
    n_cmp++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL loss_requal_release: got %b want 0", core_reset); end
    n_cmp++; if (loss_count !== 2'd1) begin n_err++; $display("FAIL loss_count_hold: got %0d want 1", loss_count); end
  endtask

  task automatic test_filter;
    int pulses;
    locked = 1'b0;
    step(LF - 1);
    locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL filter_short_core_reset i=%0d: got %b want 0", i, core_reset); end
      n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL filter_short_lock_lost i=%0d: got %b want 0", i, lock_lost); end
    end
    n_cmp++; if (loss_count !== 2'd0) begin n_err++; $display("FAIL filter_short_count: got %0d want 0", loss_count); end
    locked = 1'b0;
    step(LF + 1);
    locked = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (lock_lost === 1'b1) pulses++;
      if (i == 0) begin
        n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL filter_long_core_reset: got %b want 1", core_reset); end
      end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL filter_long_pulses: got %0d want 1", pulses); end
    n_cmp++; if (loss_count !== 2'd1) begin n_err++; $display("FAIL filter_long_count: got %0d want 1", loss_count); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL filter_requal_ready: got %b want 1", ready); end
  endtask

  task automatic test_unstable;
    apply_reset(1'b1);
    for (int i = 0; i < 100; i++) begin
      locked = ((i / 5) % 2 == 0);
      step();
      n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL unstable_core_reset i=%0d: got %b want 1", i, core_reset); end
      n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL unstable_lock_lost i=%0d: got %b want 0", i, lock_lost); end
      n_cmp++; if (pll_rst !== 1'b0) begin n_err++; $display("FAIL unstable_pll_rst i=%0d: got %b want 0", i, pll_rst); end
    end
    n_cmp++; if (loss_count !== 2'd0) begin n_err++; $display("FAIL unstable_loss_count: got %0d want 0", loss_count); end
  endtask

  // With locked low, PLL_RST is entered on edges 32, 68, 104 after release.
  task automatic test_timeout;
    logic exp_pr;
    apply_reset(1'b0);
    for (int e = 1; e <= 105; e++) begin
      step();
      exp_pr = ((e >= LT) && (e < LT + PRC)) || ((e >= 2*LT + PRC) && (e < 2*LT + 2*PRC)) ||
               (e >= 3*LT + 2*PRC);
      n_cmp++; if (pll_rst !== exp_pr) begin n_err++; $display("FAIL timeout_pll_rst e=%0d: got %b want %b", e, pll_rst, exp_pr); end
      if (e == LT - 1) begin
        n_cmp++; if (retry_count !== 2'd0) begin n_err++; $display("FAIL timeout_retry0: got %0d want 0", retry_count); end
      end
      if (e == LT) begin
        n_cmp++; if (retry_count !== 2'd1) begin n_err++; $display("FAIL timeout_retry1: got %0d want 1", retry_count); end
      end
      if (e == 2*LT + PRC) begin
        n_cmp++; if (retry_count !== 2'd2) begin n_err++; $display("FAIL timeout_retry2: got %0d want 2", retry_count); end
      end
      if (e == 3*LT + 2*PRC) begin
        n_cmp++; if (retry_count !== 2'd3) begin n_err++; $display("FAIL timeout_retry3: got %0d want 3", retry_count); end
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (pll_rst !== 1'b0) begin n_err++; $display("FAIL midpulse_pll_rst: got %b want 0", pll_rst); end
    n_cmp++; if (retry_count !== 2'd0) begin n_err++; $display("FAIL midpulse_retry: got %0d want 0", retry_count); end
    n_cmp++; if (loss_count !== 2'd0) begin n_err++; $display("FAIL midpulse_loss: got %0d want 0", loss_count); end
    n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL midpulse_core_reset: got %b want 1", core_reset); end
  endtask

  task automatic wait_ready(input string tag);
    int i;
    for (i = 0; i < 40 && ready !== 1'b1; i++) step();
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL %s_ready_timeout: got %b want 1", tag, ready); end
  endtask

  task automatic test_saturation;
    logic          seen;
    logic [CW-1:0] exp_cnt;
    apply_reset(1'b1);
    wait_ready("sat_start");
    for (int k = 1; k <= 5; k++) begin
      locked = 1'b0;
      step(DIP);
      locked = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        step();
        if (lock_lost === 1'b1) seen = 1'b1;
      end
      exp_cnt = (k >= 3) ? 2'd3 : CW'(k);
      n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL sat_pulse k=%0d: got %b want 1", k, seen); end
      n_cmp++; if (loss_count !== exp_cnt) begin n_err++; $display("FAIL sat_loss_count k=%0d: got %0d want %0d", k, loss_count, exp_cnt); end
      wait_ready("sat_requal");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_release();
`ifdef PLL_LOCK_SUPERVISOR_LOSS_FILTER_EN
    test_filter();
`else
    test_loss();
`endif
    test_unstable();
    test_timeout();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
